// File: rtl/mips_fetch_stage_if.sv
// Fetch-stage bus: program-load port, BEQ redirect inputs and the valid/ready
// instruction stream toward decode, plus the visible fetch PC.
interface mips_fetch_stage_if;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        branch_taken;
  logic [31:0] branch_pc4;
  logic [15:0] branch_imm;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc4;
  logic [31:0] pc;

  // Core/decode side: loads programs, resolves branches, consumes instructions
  modport master (
    output load_en, load_addr, load_data,
    output branch_taken, branch_pc4, branch_imm,
    output out_ready,
    input  out_valid, out_instr, out_pc4, pc
  );

  // Fetch stage side
  modport slave (
    input  load_en, load_addr, load_data,
    input  branch_taken, branch_pc4, branch_imm,
    input  out_ready,
    output out_valid, out_instr, out_pc4, pc
  );
endinterface

// File: rtl/mips_fetch_stage.sv
// MIPS instruction-fetch stage: PC, word-addressed instruction memory, BEQ redirect,
// and a one-deep registered valid/ready output toward decode.
module mips_fetch_stage #(
  parameter int          IMEM_DEPTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input logic               clock,
  input logic               reset,
  mips_fetch_stage_if.slave ifc
);

  localparam int AW = $clog2(IMEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic           do_redirect;
  logic           do_fetch;

  logic [31:0]    mem [IMEM_DEPTH];
  logic [31:0]    pc_p0;
  logic           vld_p1;
  logic [31:0]    instr_p1;
  logic [31:0]    pc4_p1;
  logic [AW-1:0]  rd_idx;
  logic [AW-1:0]  wr_idx;
  logic [31:0]    br_target;
  logic           unused_addr_bits;

  // Word-aligned BEQ target; the add wraps at 32 bits like the PC itself.
  function automatic logic [31:0] redirect_target(input logic [31:0] pc4,
                                                  input logic [15:0] imm);
    logic signed [31:0] off;
    logic        [31:0] base;
    off  = {{14{imm[15]}}, imm, 2'b00};
    base = {pc4[31:2], 2'b00};
    return base + $unsigned(off);
  endfunction

  assign rd_idx    = pc_p0[AW+1:2];
  assign wr_idx    = ifc.load_addr[AW+1:2];
  assign br_target = redirect_target(ifc.branch_pc4, ifc.branch_imm);

  assign unused_addr_bits = ^{ifc.load_addr[31:AW+2], ifc.load_addr[1:0],
                              ifc.branch_pc4[1:0]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  state_d = RUN;
      RUN: begin
        if (ifc.branch_taken)          state_d = FLUSH;
        else if (vld_p1 && !ifc.out_ready) state_d = HOLD;
        else                           state_d = RUN;
      end
      HOLD: begin
        if (ifc.branch_taken)   state_d = FLUSH;
        else if (ifc.out_ready) state_d = RUN;
        else                    state_d = HOLD;
      end
      FLUSH: begin
        if (ifc.branch_taken) state_d = FLUSH;
        else                  state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // FLUSH fetches on its exit edge so the bubble lasts exactly one cycle.
  always_comb begin
    do_redirect = 1'b0;
    do_fetch    = 1'b0;
    unique case (state_q)
      IDLE: begin
        do_redirect = 1'b0;
        do_fetch    = 1'b0;
      end
      RUN: begin
        do_redirect = ifc.branch_taken;
        do_fetch    = !ifc.branch_taken && (!vld_p1 || ifc.out_ready);
      end
      HOLD: begin
        do_redirect = ifc.branch_taken;
        do_fetch    = !ifc.branch_taken && ifc.out_ready;
      end
      FLUSH: begin
        do_redirect = ifc.branch_taken;
        do_fetch    = !ifc.branch_taken;
      end
      default: begin
        do_redirect = 1'b0;
        do_fetch    = 1'b0;
      end
    endcase
  end

  // p0 -> p1: PC read of memory into the decode-facing output register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_p0    <= RESET_PC;
      vld_p1   <= 1'b0;
      instr_p1 <= 32'h0;
      pc4_p1   <= 32'h0;
    end else if (do_redirect) begin
      pc_p0  <= br_target;
      vld_p1 <= 1'b0;
    end else if (do_fetch) begin
      instr_p1 <= mem[rd_idx];
      pc4_p1   <= pc_p0 + 32'd4;
      vld_p1   <= 1'b1;
      pc_p0    <= pc_p0 + 32'd4;
    end
  end

  // Memory survives reset; a same-edge fetch of this index sees the old word.
  always_ff @(posedge clock) begin
    if (ifc.load_en) mem[wr_idx] <= ifc.load_data;
  end

  assign ifc.out_valid = vld_p1;
  assign ifc.out_instr = instr_p1;
  assign ifc.out_pc4   = pc4_p1;
  assign ifc.pc        = pc_p0;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Directed bench for mips_fetch_stage: vector table for the run/stall/branch/alias
// cases plus hand-written asynchronous-reset sequences.
module tb_mips_fetch_stage;

  logic clock;
  logic reset;
  int   n_total;
  int   n_pass;

  mips_fetch_stage_if ifc ();

  mips_fetch_stage #(.IMEM_DEPTH(32), .RESET_PC(32'h0)) dut (
    .clock (clock),
    .reset (reset),
    .ifc   (ifc.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        ready;
    logic        br;
    logic [31:0] bpc4;
    logic [15:0] imm;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        e_vld;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs [26];

  function automatic vec_t mk(input logic ready, input logic br, input logic [31:0] bpc4,
                              input logic [15:0] imm, input logic ld_en,
                              input logic [31:0] ld_addr, input logic [31:0] ld_data,
                              input logic e_vld, input logic [31:0] e_instr,
                              input logic [31:0] e_pc4, input logic [31:0] e_pc);
    vec_t v;
    v.ready = ready; v.br = br; v.bpc4 = bpc4; v.imm = imm;
    v.ld_en = ld_en; v.ld_addr = ld_addr; v.ld_data = ld_data;
    v.e_vld = e_vld; v.e_instr = e_instr; v.e_pc4 = e_pc4; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    ifc.load_en      = 1'b0;
    ifc.load_addr    = 32'h0;
    ifc.load_data    = 32'h0;
    ifc.branch_taken = 1'b0;
    ifc.branch_pc4   = 32'h0;
    ifc.branch_imm   = 16'h0;
    ifc.out_ready    = 1'b0;
  endtask

  initial begin
    logic [31:0] word;
    n_total = 0;
    n_pass  = 0;
    reset   = 1'b1;
    idle_inputs();

    // Program load while held in reset: mem[0..1] are ADDI words, rest tagged by index
    for (int i = 0; i < 32; i++) begin
      if (i == 0)      word = 32'h2008_0005;
      else if (i == 1) word = 32'h2009_0003;
      else             word = 32'hA000_0000 | 32'(i);
      ifc.load_en   = 1'b1;
      ifc.load_addr = 32'(i) << 2;
      ifc.load_data = word;
      tick();
    end
    ifc.load_en = 1'b0;

    check("reset_valid", {31'h0, ifc.out_valid}, 32'h0);
    check("reset_instr", ifc.out_instr, 32'h0);
    check("reset_pc4",   ifc.out_pc4,   32'h0);
    check("reset_pc",    ifc.pc,        32'h0);

    //                ready br  bpc4          imm       ld  ld_addr      ld_data        vld instr          pc4           pc
    vecs[0]  = mk(1'b1, 1'b0, 32'h0,  16'h0000, 1'b0, 32'h0,  32'h0,         1'b0, 32'h0,         32'h0,  32'h0);
    vecs[1]  = mk(1'b1, 1'b0, 32'h0,  16'h0000, 1'b0, 32'h0,  32'h0,         1'b1, 32'h2008_0005, 32'h4,  32'h4);
    vecs[2]  = mk(1'b1, 1'b0, 32'h0,  16'h0000, 1'b0, 32'h0,  32'h0,         1'b1, 32'h2009_0003, 32'h8,  32'h8);
    vecs[3]  = mk(1'b0, 1'b0, 32'h0,  16'h0000, 1'b0, 32'h0,  32'h0,         1'b1, 32'h2009_0003, 32'h8,  32'h8);
    vecs[4]  = mk(1'b0, 1'b0, 32'h0,  16'h0000, 1'b0, 32'h0,  32'h0,         1'b1, 32'h2009_0003, 32'h8,  32'h8);
    vecs[5]  = mk(1'b0, 1'b0, 32'h0,  16'h0000, 1'b0, 32'h0,  32'h0,         1'b1, 32'h2009_0003, 32'h8,  32'h8);
    vecs[6]  = mk(1'b1, 1'b0, 32'h0,  16'h0000, 1'b0, 32'h0,  32'h0,         1'b1, 32'hA000_0002, 32'hC,  32'hC);
    vecs[7]  = mk(1'b1, 1'b0, 32'h0,  16'h0000, 1'b0, 32'h0,  32'h0,         1'b1, 32'hA000_0003, 32'h10, 32'h10);
    vecs[8]  = mk(1'b1, 1'b0, 32'h0,  16'h0000, 1'b0, 32'h0,  32'h0,         1'b1, 32'hA000_0004, 32'h14, 32'h14);
    // forward BEQ: 0x10 + 3*4 = 0x1C
    vecs[9]  = mk(1'b1, 1'b1, 32'h10, 16'h0003, 1'b0, 32'h0,  32'h0,         1'b0, 32'h0,         32'h0,  32'h1C);
    vecs[10] = mk(1'b1, 1'b0, 32'h0,  16'h0000, 1'b0, 32'h0,  32'h0,         1'b1, 32'hA000_0007, 32'h20, 32'h20);
    vecs[11] = mk(1'b0, 1'b0, 32'h0,  16'h0000, 1'b0, 32'h0,  32'h0,         1'b1, 32'hA000_0007, 32'h20, 32'h20);
    // backward BEQ from HOLD: 0x14 - 5*4 = 0x0, held word dropped
    vecs[12] = mk(1'b0, 1'b1, 32'h14, 16'hFFFB, 1'b0, 32'h0,  32'h0,         1'b0, 32'h0,         32'h0,  32'h0);
    vecs[13] = mk(1'b1, 1'b0, 32'h0,  16'h0000, 1'b0, 32'h0,  32'h0,         1'b1, 32'h2008_0005, 32'h4,  32'h4);
    vecs[14] = mk(1'b1, 1'b0, 32'h0,  16'h0000, 1'b0, 32'h0,  32'h0,         1'b1, 32'h2009_0003, 32'h8,  32'h8);
    // branch to 0x80 aliases index 0; load to 0x83 (index 0) during that fetch
    vecs[15] = mk(1'b1, 1'b1, 32'h7C, 16'h0001, 1'b0, 32'h0,  32'h0,         1'b0, 32'h0,         32'h0,  32'h80);
    vecs[16] = mk(1'b1, 1'b0, 32'h0,  16'h0000, 1'b1, 32'h83, 32'hDEAD_BEEF, 1'b1, 32'h2008_0005, 32'h84, 32'h84);
    vecs[17] = mk(1'b1, 1'b0, 32'h0,  16'h0000, 1'b0, 32'h0,  32'h0,         1'b1, 32'h2009_0003, 32'h88, 32'h88);
    vecs[18] = mk(1'b1, 1'b1, 32'h4,  16'hFFFF, 1'b0, 32'h0,  32'h0,         1'b0, 32'h0,         32'h0,  32'h0);
    vecs[19] = mk(1'b1, 1'b0, 32'h0,  16'h0000, 1'b0, 32'h0,  32'h0,         1'b1, 32'hDEAD_BEEF, 32'h4,  32'h4);
    // PC wrap: target 0xFFFFFFFC -> index 31, then pc4 wraps to 0
    vecs[20] = mk(1'b1, 1'b1, 32'h0,  16'hFFFF, 1'b0, 32'h0,  32'h0,         1'b0, 32'h0,         32'h0,  32'hFFFF_FFFC);
    vecs[21] = mk(1'b1, 1'b0, 32'h0,  16'h0000, 1'b0, 32'h0,  32'h0,         1'b1, 32'hA000_001F, 32'h0,  32'h0);
    vecs[22] = mk(1'b1, 1'b0, 32'h0,  16'h0000, 1'b0, 32'h0,  32'h0,         1'b1, 32'hDEAD_BEEF, 32'h4,  32'h4);
    // branch while already flushing retargets
    vecs[23] = mk(1'b1, 1'b1, 32'h40, 16'h0000, 1'b0, 32'h0,  32'h0,         1'b0, 32'h0,         32'h0,  32'h40);
    vecs[24] = mk(1'b1, 1'b1, 32'h8,  16'h0001, 1'b0, 32'h0,  32'h0,         1'b0, 32'h0,         32'h0,  32'hC);
    vecs[25] = mk(1'b1, 1'b0, 32'h0,  16'h0000, 1'b0, 32'h0,  32'h0,         1'b1, 32'hA000_0003, 32'h10, 32'h10);

    reset = 1'b0;
    for (int k = 0; k < 26; k++) begin
      ifc.out_ready    = vecs[k].ready;
      ifc.branch_taken = vecs[k].br;
      ifc.branch_pc4   = vecs[k].bpc4;
      ifc.branch_imm   = vecs[k].imm;
      ifc.load_en      = vecs[k].ld_en;
      ifc.load_addr    = vecs[k].ld_addr;
      ifc.load_data    = vecs[k].ld_data;
      tick();
      check($sformatf("v%0d_valid", k), {31'h0, ifc.out_valid}, {31'h0, vecs[k].e_vld});
      check($sformatf("v%0d_pc", k), ifc.pc, vecs[k].e_pc);
      if (vecs[k].e_vld) begin
        check($sformatf("v%0d_instr", k), ifc.out_instr, vecs[k].e_instr);
        check($sformatf("v%0d_pc4", k), ifc.out_pc4, vecs[k].e_pc4);
      end
    end
    idle_inputs();

    // Reset asserted mid-stall, redirect requested during and after reset is ignored
    ifc.out_ready = 1'b0;
    tick();
    check("hold_instr", ifc.out_instr, 32'hA000_0003);
    reset = 1'b1;
    #1;
    check("rst_hold_valid", {31'h0, ifc.out_valid}, 32'h0);
    check("rst_hold_pc",    ifc.pc,        32'h0);
    check("rst_hold_instr", ifc.out_instr, 32'h0);
    check("rst_hold_pc4",   ifc.out_pc4,   32'h0);
    ifc.branch_taken = 1'b1;
    ifc.branch_pc4   = 32'h40;
    ifc.branch_imm   = 16'h0;
    tick();
    check("rst_branch_pc", ifc.pc, 32'h0);
    reset = 1'b0;
    tick();
    check("idle_valid", {31'h0, ifc.out_valid}, 32'h0);
    check("idle_pc",    ifc.pc, 32'h0);
    ifc.branch_taken = 1'b0;
    ifc.out_ready    = 1'b1;
    tick();
    check("post_rst_valid", {31'h0, ifc.out_valid}, 32'h1);
    check("post_rst_instr", ifc.out_instr, 32'hDEAD_BEEF);
    check("post_rst_pc4",   ifc.out_pc4,   32'h4);

    // Reset asserted mid-flush discards the pending target
    ifc.branch_taken = 1'b1;
    ifc.branch_pc4   = 32'h40;
    ifc.branch_imm   = 16'h0;
    tick();
    check("flush_pc", ifc.pc, 32'h40);
    ifc.branch_taken = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    check("rst_flush_pc",    ifc.pc, 32'h0);
    check("rst_flush_valid", {31'h0, ifc.out_valid}, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    check("flush_idle_valid", {31'h0, ifc.out_valid}, 32'h0);
    tick();
    check("flush_rec_instr", ifc.out_instr, 32'hDEAD_BEEF);
    check("flush_rec_pc4",   ifc.out_pc4,   32'h4);
    check("flush_rec_pc",    ifc.pc,        32'h4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
